// File: rtl/exce_trap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exce_trap_pkg
// Description : Cause codes, priority table and FSM encoding for exce_trap.
// Revision    : 1.0 - initial release
// ============================================================================
package exce_trap_pkg;

  localparam logic [3:0] EXC_IAM = 4'd0;
  localparam logic [3:0] EXC_IAF = 4'd1;
  localparam logic [3:0] EXC_LAM = 4'd4;
  localparam logic [3:0] EXC_LAF = 4'd5;
  localparam logic [3:0] EXC_SAM = 4'd6;
  localparam logic [3:0] EXC_SAF = 4'd7;
  localparam logic [3:0] EXC_IPF = 4'd12;
  localparam logic [3:0] EXC_LPF = 4'd13;
  localparam logic [3:0] EXC_SPF = 4'd15;

  localparam int N_CAUSE = 9;

  // Codes packed by rank: slice 0 belongs to the highest-priority request.
  localparam logic [4*N_CAUSE-1:0] EXC_PRIO_CODES = {
    EXC_LAF, EXC_SAF, EXC_LPF, EXC_SPF, EXC_LAM,
    EXC_SAM, EXC_IAM, EXC_IAF, EXC_IPF
  };

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    HOLD = 2'b10
  } trap_state_e;

endpackage
`default_nettype wire

// File: rtl/exce_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : exce_prio_enc
// Description : 9-input priority encoder; req[0] is the highest rank.
// Revision    : 1.0 - initial release
// ============================================================================
module exce_prio_enc
  import exce_trap_pkg::*;
#(
  parameter logic [4*N_CAUSE-1:0] CODES = EXC_PRIO_CODES
) (
  input  logic [N_CAUSE-1:0] req,
  output logic [3:0]         code,
  output logic               valid
);

  // Scan from lowest rank upward so the highest asserted rank is written last.
  always_comb begin
    code  = 4'd0;
    valid = |req;
    for (int i = N_CAUSE - 1; i >= 0; i--) begin
      if (req[i]) code = CODES[4*i +: 4];
    end
  end

endmodule
`default_nettype wire

// File: rtl/exce_trap.sv
`default_nettype none
// ============================================================================
// Module      : exce_trap
// Description : Latches the first BIU fault, handshakes a trap with the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module exce_trap
  import exce_trap_pkg::*;
#(
  parameter int unsigned HOLDOFF  = 2,
  parameter bit          MTVAL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ins_addr_mis,
  input  logic        ins_acc_fault,
  input  logic        load_addr_mis,
  input  logic        load_acc_fault,
  input  logic        st_addr_mis,
  input  logic        st_acc_fault,
  input  logic        ins_page_fault,
  input  logic        ld_page_fault,
  input  logic        st_page_fault,
  input  logic [31:0] fault_addr,
  input  logic        flush,
  input  logic        trap_ack,
  output logic        trap_req,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic        exce_busy
);

  localparam logic [3:0] c_hold_load = 4'(HOLDOFF - 1);

  logic [N_CAUSE-1:0] w_req;
  logic [3:0]         w_code;
  logic               w_valid;
  trap_state_e        r_state;
  trap_state_e        w_state_nxt;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;
  logic               w_capture;
  logic [3:0]         r_code;
  logic [31:0]        r_mtval;

  // Rank order must match EXC_PRIO_CODES.
  assign w_req = {load_acc_fault, st_acc_fault, ld_page_fault, st_page_fault,
                  load_addr_mis, st_addr_mis, ins_addr_mis, ins_acc_fault,
                  ins_page_fault};

  exce_prio_enc u_prio_enc (
    .req   (w_req),
    .code  (w_code),
    .valid (w_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            w_capture   = 1'b1;
            w_state_nxt = PEND;
          end
        end
        PEND: begin
          if (trap_ack) begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = c_hold_load;
          end
        end
        HOLD: begin
          if (r_cnt == 4'd0) w_state_nxt = IDLE;
          else               w_cnt_nxt   = r_cnt - 4'd1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_code  <= 4'd0;
      r_mtval <= 32'd0;
    end else if (w_capture) begin
      r_code  <= w_code;
      r_mtval <= MTVAL_EN ? fault_addr : 32'd0;
    end
  end

  assign trap_req  = (r_state == PEND);
  assign exce_busy = (r_state != IDLE);
  assign mcause    = {28'd0, r_code};
  assign mtval     = r_mtval;

endmodule
`default_nettype wire

// File: tb/tb_exce_trap.sv
`default_nettype none
// ============================================================================
// Module      : tb_exce_trap
// Description : Table, directed and random checks of exce_trap vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exce_trap;

  // Bench-local strobe bit positions (independent of the RTL packing).
  localparam logic [8:0] B_IAM = 9'h001;
  localparam logic [8:0] B_IAF = 9'h002;
  localparam logic [8:0] B_LAM = 9'h004;
  localparam logic [8:0] B_LAF = 9'h008;
  localparam logic [8:0] B_SAM = 9'h010;
  localparam logic [8:0] B_SAF = 9'h020;
  localparam logic [8:0] B_IPF = 9'h040;
  localparam logic [8:0] B_LPF = 9'h080;
  localparam logic [8:0] B_SPF = 9'h100;

  typedef struct {
    bit          pending;
    int          hold_left;
    logic [3:0]  code;
    logic [31:0] tval;
  } mdl_t;

  typedef struct {
    logic [8:0]  s;
    logic [31:0] a;
    bit          f;
    bit          k;
    bit          req;
    bit          busy;
    logic [3:0]  cause;
    logic [31:0] tval;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  s = 9'd0;
  logic [31:0] addr = 32'd0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;

  logic        req_a, busy_a, req_b, busy_b;
  logic [31:0] cause_a, tval_a, cause_b, tval_b;

  int checks = 0;
  int errors = 0;
  mdl_t ma, mb;
  vec_t tbl[22];

  always #5 clk = ~clk;

  exce_trap #(.HOLDOFF(2), .MTVAL_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .ins_addr_mis(s[0]), .ins_acc_fault(s[1]), .load_addr_mis(s[2]),
    .load_acc_fault(s[3]), .st_addr_mis(s[4]), .st_acc_fault(s[5]),
    .ins_page_fault(s[6]), .ld_page_fault(s[7]), .st_page_fault(s[8]),
    .fault_addr(addr), .flush(flush), .trap_ack(ack),
    .trap_req(req_a), .mcause(cause_a), .mtval(tval_a), .exce_busy(busy_a)
  );

  exce_trap #(.HOLDOFF(3), .MTVAL_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .ins_addr_mis(s[0]), .ins_acc_fault(s[1]), .load_addr_mis(s[2]),
    .load_acc_fault(s[3]), .st_addr_mis(s[4]), .st_acc_fault(s[5]),
    .ins_page_fault(s[6]), .ld_page_fault(s[7]), .st_page_fault(s[8]),
    .fault_addr(addr), .flush(flush), .trap_ack(ack),
    .trap_req(req_b), .mcause(cause_b), .mtval(tval_b), .exce_busy(busy_b)
  );

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.pending = 1'b0; m.hold_left = 0; m.code = 4'd0; m.tval = 32'd0;
    return m;
  endfunction

  // One clock edge of the trap unit, written from the cause-priority rules.
  function automatic mdl_t mdl_step(mdl_t m, int holdoff, bit mten,
                                    logic [8:0] st, logic [31:0] a, bit f, bit k);
    logic [8:0] prio_mask[9];
    logic [3:0] prio_code[9];
    prio_mask = '{B_IPF, B_IAF, B_IAM, B_SAM, B_LAM, B_SPF, B_LPF, B_SAF, B_LAF};
    prio_code = '{4'd12, 4'd1, 4'd0, 4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5};
    if (f) begin
      m.pending = 1'b0;
      m.hold_left = 0;
    end else if (!m.pending && m.hold_left == 0) begin
      if (st != 9'd0) begin
        m.pending = 1'b1;
        m.tval = mten ? a : 32'd0;
        for (int i = 8; i >= 0; i--)
          if ((st & prio_mask[i]) != 9'd0) m.code = prio_code[i];
      end
    end else if (m.pending) begin
      if (k) begin
        m.pending = 1'b0;
        m.hold_left = holdoff;
      end
    end else begin
      m.hold_left = m.hold_left - 1;
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_models();
    check("a_req",    {31'd0, req_a},  {31'd0, ma.pending});
    check("a_busy",   {31'd0, busy_a}, {31'd0, (ma.pending || ma.hold_left > 0)});
    check("a_mcause", cause_a, {28'd0, ma.code});
    check("a_mtval",  tval_a,  ma.tval);
    check("b_req",    {31'd0, req_b},  {31'd0, mb.pending});
    check("b_busy",   {31'd0, busy_b}, {31'd0, (mb.pending || mb.hold_left > 0)});
    check("b_mcause", cause_b, {28'd0, mb.code});
    check("b_mtval",  tval_b,  32'd0);
  endtask

  task automatic step(input logic [8:0] s_i, input logic [31:0] a_i, input bit f_i, input bit k_i);
    @(negedge clk);
    s = s_i; addr = a_i; flush = f_i; ack = k_i;
    @(posedge clk);
    ma = mdl_step(ma, 2, 1'b1, s_i, a_i, f_i, k_i);
    mb = mdl_step(mb, 3, 1'b0, s_i, a_i, f_i, k_i);
    #1;
    check_models();
  endtask

  initial begin
    // Hand-derived expectations for dut_a (HOLDOFF = 2, MTVAL_EN = 1).
    tbl[0]  = '{B_LAF, 32'h8000_1004, 0, 0, 1, 1, 4'd5,  32'h8000_1004};
    tbl[1]  = '{9'd0,  32'h0,         0, 0, 1, 1, 4'd5,  32'h8000_1004};
    tbl[2]  = '{9'd0,  32'h0,         0, 1, 0, 1, 4'd5,  32'h8000_1004};
    tbl[3]  = '{9'd0,  32'h0,         0, 0, 0, 1, 4'd5,  32'h8000_1004};
    tbl[4]  = '{9'd0,  32'h0,         0, 0, 0, 0, 4'd5,  32'h8000_1004};
    tbl[5]  = '{B_IPF | B_IAF | B_IAM, 32'h0000_0102, 0, 0, 1, 1, 4'd12, 32'h0000_0102};
    tbl[6]  = '{9'd0,  32'h0,         0, 1, 0, 1, 4'd12, 32'h0000_0102};
    tbl[7]  = '{9'd0,  32'h0,         0, 0, 0, 1, 4'd12, 32'h0000_0102};
    tbl[8]  = '{9'd0,  32'h0,         0, 0, 0, 0, 4'd12, 32'h0000_0102};
    tbl[9]  = '{B_SAM | B_SPF, 32'hAAAA_0000, 0, 0, 1, 1, 4'd6, 32'hAAAA_0000};
    tbl[10] = '{9'd0,  32'h0,         1, 0, 0, 0, 4'd6,  32'hAAAA_0000};
    tbl[11] = '{B_SPF, 32'h0000_1234, 0, 0, 1, 1, 4'd15, 32'h0000_1234};
    tbl[12] = '{9'd0,  32'h0,         0, 0, 1, 1, 4'd15, 32'h0000_1234};
    tbl[13] = '{B_LPF, 32'h0000_5678, 0, 0, 1, 1, 4'd15, 32'h0000_1234};
    tbl[14] = '{B_IAF, 32'h0000_0009, 1, 1, 0, 0, 4'd15, 32'h0000_1234};
    tbl[15] = '{B_IAF, 32'h0000_0009, 1, 0, 0, 0, 4'd15, 32'h0000_1234};
    tbl[16] = '{B_SAF, 32'h0000_0040, 0, 0, 1, 1, 4'd7,  32'h0000_0040};
    tbl[17] = '{B_SAF, 32'h0000_0044, 0, 1, 0, 1, 4'd7,  32'h0000_0040};
    tbl[18] = '{B_SAF, 32'h0000_0048, 0, 0, 0, 1, 4'd7,  32'h0000_0040};
    tbl[19] = '{B_SAF, 32'h0000_004C, 0, 0, 0, 0, 4'd7,  32'h0000_0040};
    tbl[20] = '{9'd0,  32'h0,         0, 0, 0, 0, 4'd7,  32'h0000_0040};
    tbl[21] = '{9'd0,  32'h0,         0, 1, 0, 0, 4'd7,  32'h0000_0040};

    ma = mdl_reset();
    mb = mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    check_models();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].s, tbl[i].a, tbl[i].f, tbl[i].k);
      check($sformatf("t%0d_req", i),    {31'd0, req_a},  {31'd0, tbl[i].req});
      check($sformatf("t%0d_busy", i),   {31'd0, busy_a}, {31'd0, tbl[i].busy});
      check($sformatf("t%0d_mcause", i), cause_a, {28'd0, tbl[i].cause});
      check($sformatf("t%0d_mtval", i),  tval_a,  tbl[i].tval);
    end

    // Asynchronous reset between edges while a trap is pending.
    step(B_LAM, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("pend_before_rst", {31'd0, req_a}, 32'd1);
    @(negedge clk);
    s = 9'd0; addr = 32'd0;
    #2 rst = 1'b0;
    #1;
    ma = mdl_reset();
    mb = mdl_reset();
    check_models();
    check("rst_async_mtval", tval_a, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      logic [8:0]  rs;
      logic [31:0] ra;
      rs = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(1, 511)) : 9'd0;
      ra = $urandom;
      step(rs, ra, ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
